// File: rtl/sequential_wide_adder.sv
// ---------------------------------------------------------------------------
// sequential_wide_adder
//   Adds two WIDTH-bit operands plus a carry-in over N = WIDTH/CHUNK clock
//   cycles, one CHUNK-bit slice per cycle (LSB slice first), reusing a single
//   CHUNK-wide carry_select_adder. The slice carry-out is registered and fed
//   back as the carry-in of the next slice.
//
//   Ports
//     iClk    in   1      clock, rising edge
//     iRstN   in   1      asynchronous active-low reset
//     iValid  in   1      operand request valid
//     oReady  out  1      operands can be accepted (IDLE only)
//     iA, iB  in   WIDTH  operands
//     iC      in   1      carry-in
//     oValid  out  1      result valid (DONE only)
//     iReady  in   1      downstream accepts the result
//     oS      out  WIDTH  sum, modulo 2^WIDTH
//     oC      out  1      carry-out (bit WIDTH of A+B+C)
//
//   Also contains carry_select_adder, the CHUNK-wide combinational adder
//   used for each slice.
// ---------------------------------------------------------------------------

// carry_select_adder
//   Combinational WIDTH-bit adder built from BLOCK_WIDTH-bit blocks. Each block
//   precomputes its sum for carry-in 0 and 1; the incoming block carry selects.
//   Ports: iA, iB (WIDTH), iC (carry-in) -> oS (WIDTH), oC (carry-out).
module carry_select_adder #(
    parameter int WIDTH       = 16,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic [WIDTH-1:0] oS,
    output logic             oC
);
    localparam int NB = WIDTH / BLOCK_WIDTH;

    logic [NB:0] carry;

    assign carry[0] = iC;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLOCK_WIDTH:0] sum0;
        logic [BLOCK_WIDTH:0] sum1;

        // sum0 is at most 2^(BW+1)-2, so sum0+1 never overflows BW+1 bits.
        assign sum0 = {1'b0, iA[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + {1'b0, iB[g*BLOCK_WIDTH +: BLOCK_WIDTH]};
        assign sum1 = sum0 + (BLOCK_WIDTH+1)'(1);

        assign oS[g*BLOCK_WIDTH +: BLOCK_WIDTH] = carry[g] ? sum1[BLOCK_WIDTH-1:0]
                                                           : sum0[BLOCK_WIDTH-1:0];
        assign carry[g+1] = carry[g] ? sum1[BLOCK_WIDTH] : sum0[BLOCK_WIDTH];
    end

    assign oC = carry[NB];
endmodule

module sequential_wide_adder #(
    parameter int WIDTH       = 64,
    parameter int CHUNK       = 16,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oS,
    output logic             oC
);
    localparam int N = WIDTH / CHUNK;
    localparam int K = (N > 1) ? $clog2(N) : 1;
    localparam logic [K-1:0] LAST_CNT = K'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  sum;
    logic              carry;
    logic [K-1:0]      cnt;

    logic              accept;
    logic              last;
    logic [31:0]       slice_base;
    logic [CHUNK-1:0]  slice_a;
    logic [CHUNK-1:0]  slice_b;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_carry;
    logic [WIDTH-1:0]  slice_mask;

    assign accept = iValid && (state == IDLE);
    assign last   = (cnt == LAST_CNT);

    // Slice selection and write-back use shifts by cnt*CHUNK rather than
    // variable part-selects so that N==1 (WIDTH==CHUNK) needs no special case.
    assign slice_base = 32'(cnt) * CHUNK;
    assign slice_a    = CHUNK'(op_a >> slice_base);
    assign slice_b    = CHUNK'(op_b >> slice_base);
    assign slice_mask = WIDTH'({CHUNK{1'b1}}) << slice_base;

    carry_select_adder #(
        .WIDTH       (CHUNK),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_slice_adder (
        .iA (slice_a),
        .iB (slice_b),
        .iC (carry),
        .oS (slice_sum),
        .oC (slice_carry)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iValid) state_next = ADD;
            ADD:     if (last)   state_next = DONE;
            DONE:    if (iReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            op_a  <= iA;
            op_b  <= iB;
            carry <= iC;
            cnt   <= '0;
        end else if (state == ADD) begin
            sum   <= (sum & ~slice_mask) | (WIDTH'(slice_sum) << slice_base);
            carry <= slice_carry;
            cnt   <= cnt + K'(1);
        end
    end

    // Outputs come straight from registers; nothing from iA/iB/iValid leaks
    // combinationally to oS/oC.
    assign oReady = (state == IDLE);
    assign oValid = (state == DONE);
    assign oS     = sum;
    assign oC     = carry;
endmodule

// File: tb/tb_sequential_wide_adder.sv
module tb_sequential_wide_adder;
    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int BW    = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic             out_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_c;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int results = 0;
    int driver_done = 0;

    // Expected {carry, sum} for every accepted request, oldest first.
    logic [WIDTH:0] exp_q[$];

    always #5 clk = ~clk;

    sequential_wide_adder #(
        .WIDTH       (WIDTH),
        .CHUNK       (CHUNK),
        .BLOCK_WIDTH (BW)
    ) dut (
        .iClk   (clk),
        .iRstN  (rst_n),
        .iValid (in_valid),
        .oReady (out_ready),
        .iA     (in_a),
        .iB     (in_b),
        .iC     (in_c),
        .oValid (out_valid),
        .iReady (in_ready),
        .oS     (out_s),
        .oC     (out_c)
    );

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: the full-width sum computed in one step on acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && out_ready) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(in_c));
                accepts++;
            end
            if (out_valid && in_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                results++;
            end
        end
    end

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding request; ready and valid are never high together.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_valid_exclusive", (WIDTH+1)'(out_ready & out_valid), '0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h required=none", {out_c, out_s});
                end else begin
                    check("stream_result", {out_c, out_s}, exp_q[0]);
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge with out_ready high.
    task automatic wait_ready();
        for (int n = 0; n < 100; n++) begin
            if (out_ready) return;
            @(negedge clk);
        end
        check("wait_ready_timeout", (WIDTH+1)'(out_ready), (WIDTH+1)'(1));
    endtask

    // Issue one request, measure latency to oValid, compare against a
    // hand-computed value. Leaves the result presented (in_ready low).
    task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic [WIDTH:0] expected);
        int lat;
        wait_ready();
        in_a = a;
        in_b = b;
        in_c = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = ~a;
        in_b = ~b;
        in_c = ~c;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_latency"}, (WIDTH+1)'(lat), (WIDTH+1)'(N));
        check({name, "_sum"}, {out_c, out_s}, expected);
    endtask

    task automatic release_result(input string name);
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, (WIDTH+1)'(out_valid), '0);
        check({name, "_ready_back"}, (WIDTH+1)'(out_ready), (WIDTH+1)'(1));
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [WIDTH:0] held;
        int acc_snap;
        int res_snap;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        in_c = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", (WIDTH+1)'(out_ready), (WIDTH+1)'(1));
        check("reset_valid", (WIDTH+1)'(out_valid), '0);
        check("reset_sum", {out_c, out_s}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1..T3: directed carries
        do_op("t1_full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 65'h1_0000_0000_0000_0000);
        release_result("t1");
        do_op("t2_carry_in", 64'h0, 64'h0, 1'b1, 65'h0_0000_0000_0000_0001);
        release_result("t2");
        do_op("t3_slice_boundary", 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 65'h0_0000_0001_0000_0000);
        release_result("t3");

        // T4: backpressure with an ignored request while DONE
        do_op("t4_first", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
              65'h0_2222_2222_2222_2212);
        held = {out_c, out_s};
        acc_snap = accepts;
        in_a = 64'd5;
        in_b = 64'd5;
        in_c = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("t4_hold_sum", {out_c, out_s}, held);
            check("t4_hold_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(1));
            check("t4_hold_not_ready", (WIDTH+1)'(out_ready), '0);
        end
        in_valid = 1'b0;
        check("t4_no_accept", (WIDTH+1)'(accepts), (WIDTH+1)'(acc_snap));
        release_result("t4");
        do_op("t4_second", 64'd5, 64'd0, 1'b0, 65'd5);
        release_result("t4b");

        // T5: asynchronous reset while slice 2 is being added
        wait_ready();
        in_a = 64'hAAAA_BBBB_CCCC_DDDD;
        in_b = 64'h1111_2222_3333_4444;
        in_c = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_abort_valid", (WIDTH+1)'(out_valid), '0);
        check("t5_abort_ready", (WIDTH+1)'(out_ready), (WIDTH+1)'(1));
        check("t5_abort_sum", {out_c, out_s}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("t5_after_reset", 64'd3, 64'd4, 1'b0, 65'd7);
        release_result("t5");

        // T6: random stream with random gaps and backpressure
        acc_snap = accepts;
        res_snap = results;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    bit taken;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    in_a = {$urandom, $urandom};
                    in_b = {$urandom, $urandom};
                    in_c = 1'($urandom_range(0, 1));
                    if (i % 8 == 0) in_a = '1;
                    if (i % 16 == 4) in_b = ~in_a;
                    in_valid = 1'b1;
                    taken = 1'b0;
                    for (int t = 0; t < 200; t++) begin
                        @(posedge clk);
                        if (out_ready) begin
                            taken = 1'b1;
                            break;
                        end
                    end
                    #1;
                    in_valid = 1'b0;
                    if (!taken) begin
                        check("t6_accept_timeout", '0, (WIDTH+1)'(1));
                        break;
                    end
                    @(negedge clk);
                end
                driver_done = 1;
            end
            begin
                while (driver_done == 0) begin
                    @(negedge clk);
                    in_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(negedge clk);
        in_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        in_ready = 1'b0;
        check("t6_drained", (WIDTH+1)'(exp_q.size()), '0);
        check("t6_one_result_per_accept", (WIDTH+1)'(results - res_snap),
              (WIDTH+1)'(accepts - acc_snap));
        check("t6_all_accepted", (WIDTH+1)'(accepts - acc_snap), (WIDTH+1)'(2000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
